mem_access_unit: RTL and testbench

- Memory stage of the RV32IF pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Runs load/store transactions on the data-memory bus with a req/ack handshake.
- Aligns and sign/zero-extends load data and generates store byte enables.
- Stalls the front of the pipeline while a bus access is outstanding, and presents the MEM-stage data/control set that the MEM/WB register captures.

---
 rtl/mem_access_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM stage of the RV32IF pipeline: drives the data-memory req/ack bus, formats
// load/store data, stalls the front end while an access is outstanding.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] fpu_result_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        fp_op_in,
  input  logic        fp_reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] alu_result_mem,
  output logic [31:0] mem_rdata_mem,
  output logic [31:0] fpu_result_mem,
  output logic [4:0]  rd_mem,
  output logic        reg_write_mem,
  output logic        mem_to_reg_mem,
  output logic        fp_op_mem,
  output logic        fp_reg_write_mem,
  output logic        misalign_exc,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic [1:0]  lane_r;
  logic [2:0]  f3_r;
  logic        memop_s, legal_f3_s, misal_s, go_s, timeout_s;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [31:0] sh;
    sh = d >> {lane, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  fmt_load = {24'h000000, sh[7:0]};
      3'b101:  fmt_load = {16'h0000, sh[15:0]};
      default: fmt_load = d;
    endcase
  endfunction

  function automatic logic [31:0] st_wdata(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   st_wdata = {4{d[7:0]}};
      2'b01:   st_wdata = {2{d[15:0]}};
      default: st_wdata = d;
    endcase
  endfunction

  function automatic logic [3:0] st_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   st_be = 4'b0001 << lane;
      2'b01:   st_be = 4'b0011 << lane;
      default: st_be = 4'b1111;
    endcase
  endfunction

  assign memop_s    = ex_valid & (mem_read_in | mem_write_in);
  assign legal_f3_s = (funct3_in == 3'b000) | (funct3_in == 3'b001) | (funct3_in == 3'b010) |
                      (funct3_in == 3'b100) | (funct3_in == 3'b101);
  assign misal_s    = ((funct3_in[1:0] == 2'b01) & addr_in[0]) |
                      ((funct3_in[1:0] == 2'b10) & (addr_in[1:0] != 2'b00));
  assign go_s       = memop_s & legal_f3_s & ~misal_s;
  assign timeout_s  = (cnt_r == CNT_LAST) & ~dmem_ack;

  assign alu_result_mem = addr_in;
  assign fpu_result_mem = fpu_result_in;
  assign rd_mem         = rd_in;
  assign mem_rdata_mem  = rdata_r;
  assign bus_err        = err_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) state_nxt_s = ST_REQ;
        else      state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (dmem_ack || timeout_s) state_nxt_s = ST_RESP;
        else                       state_nxt_s = ST_REQ;
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bus fields, timeout counter, captured load data and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wdata <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      cnt_r      <= 8'd0;
      rdata_r    <= 32'h0000_0000;
      err_r      <= 1'b0;
      lane_r     <= 2'b00;
      f3_r       <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 8'd0;
          err_r <= 1'b0;
          if (go_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= {addr_in[31:2], 2'b00};
            dmem_wdata <= st_wdata(store_data_in, funct3_in[1:0]);
            dmem_be    <= mem_write_in ? st_be(funct3_in[1:0], addr_in[1:0]) : 4'b1111;
            lane_r     <= addr_in[1:0];
            f3_r       <= funct3_in;
          end else begin
            dmem_req <= 1'b0;
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'b0000;
            rdata_r  <= fmt_load(dmem_rdata, f3_r, lane_r);
            cnt_r    <= 8'd0;
          end else if (timeout_s) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'b0000;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b1;
            cnt_r    <= 8'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= 8'd0;
          err_r <= 1'b0;
        end
      endcase
    end
  end

  // Stall, exception and MEM/WB control outputs; forced quiet while in reset
  always_comb begin
    mem_stall        = 1'b0;
    misalign_exc     = 1'b0;
    reg_write_mem    = reg_write_in;
    mem_to_reg_mem   = mem_to_reg_in;
    fp_op_mem        = fp_op_in;
    fp_reg_write_mem = fp_reg_write_in;
    case (state_r)
      ST_IDLE: begin
        if (memop_s && !(legal_f3_s && !misal_s)) begin
          misalign_exc     = 1'b1;
          reg_write_mem    = 1'b0;
          fp_reg_write_mem = 1'b0;
        end else if (memop_s) begin
          mem_stall        = 1'b1;
          reg_write_mem    = 1'b0;
          fp_reg_write_mem = 1'b0;
          mem_to_reg_mem   = 1'b0;
        end else begin
          mem_stall = 1'b0;
        end
      end
      ST_REQ: begin
        mem_stall        = 1'b1;
        reg_write_mem    = 1'b0;
        fp_reg_write_mem = 1'b0;
        mem_to_reg_mem   = 1'b0;
      end
      ST_RESP: begin
        if (err_r) begin
          reg_write_mem    = 1'b0;
          fp_reg_write_mem = 1'b0;
        end else begin
          mem_stall = 1'b0;
        end
      end
      default: mem_stall = 1'b0;
    endcase
    if (!rst_n) begin
      mem_stall        = 1'b0;
      misalign_exc     = 1'b0;
      reg_write_mem    = 1'b0;
      mem_to_reg_mem   = 1'b0;
      fp_op_mem        = 1'b0;
      fp_reg_write_mem = 1'b0;
    end else begin
      misalign_exc = misalign_exc;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, bus timeout
// and reset during an outstanding request.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] store_data_in = 32'h0;
  logic [31:0] fpu_result_in = 32'h0;
  logic [2:0]  funct3_in = 3'b000;
  logic [4:0]  rd_in = 5'd0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic        fp_op_in = 1'b0;
  logic        fp_reg_write_in = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;
  logic        mem_stall;
  logic [31:0] alu_result_mem, mem_rdata_mem, fpu_result_mem;
  logic [4:0]  rd_mem;
  logic        reg_write_mem, mem_to_reg_mem, fp_op_mem, fp_reg_write_mem;
  logic        misalign_exc, bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .addr_in(addr_in),
    .store_data_in(store_data_in), .fpu_result_in(fpu_result_in), .funct3_in(funct3_in),
    .rd_in(rd_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .fp_op_in(fp_op_in),
    .fp_reg_write_in(fp_reg_write_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .alu_result_mem(alu_result_mem), .mem_rdata_mem(mem_rdata_mem),
    .fpu_result_mem(fpu_result_mem), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .mem_to_reg_mem(mem_to_reg_mem), .fp_op_mem(fp_op_mem),
    .fp_reg_write_mem(fp_reg_write_mem), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    ex_valid     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    dmem_ack     = 1'b0;
  endtask

  // Presents one memop and runs it until the stall clears; returns at the
  // falling edge of the first non-stalled cycle with the request fields seen.
  task automatic mem_op(input logic [31:0] a, input logic [2:0] f3, input logic wr,
                        input logic [31:0] sd, input logic [31:0] rdat, input int ack_wait,
                        output int stall_n, output int req_n, output logic we_seen,
                        output logic [3:0] be_seen, output logic [31:0] addr_seen,
                        output logic [31:0] wdata_seen);
    ex_valid      = 1'b1;
    addr_in       = a;
    funct3_in     = f3;
    mem_read_in   = ~wr;
    mem_write_in  = wr;
    store_data_in = sd;
    reg_write_in  = ~wr;
    mem_to_reg_in = ~wr;
    rd_in         = 5'd7;
    stall_n = 0;
    req_n   = 0;
    we_seen = 1'b0;
    be_seen = 4'b0000;
    addr_seen  = 32'h0;
    wdata_seen = 32'h0;
    for (int c = 0; c < 40; c++) begin
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (req_n == 0) begin
          we_seen    = dmem_we;
          be_seen    = dmem_be;
          addr_seen  = dmem_addr;
          wdata_seen = dmem_wdata;
        end
        if (req_n == ack_wait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdat;
        end
        req_n++;
      end
      @(negedge clk);
      if (!mem_stall) break;
      stall_n++;
      tick();
    end
  endtask

  int          st_n, rq_n;
  logic        we_s;
  logic [3:0]  be_s;
  logic [31:0] ad_s, wd_s;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_write_in  = 1'b1;
    fpu_result_in = 32'h3F80_0000;
    #12;
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_rw", {31'd0, reg_write_mem}, 32'd0);
    check("rst_rdata", mem_rdata_mem, 32'h0);
    check("rst_buserr", {31'd0, bus_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // LW, ack in first REQ cycle
    mem_op(32'h100, 3'b010, 1'b0, 32'h0, 32'hDEADBEEF, 0, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("lw_stall", st_n, 32'd2);
    check("lw_rdata", mem_rdata_mem, 32'hDEADBEEF);
    check("lw_rw", {31'd0, reg_write_mem}, 32'd1);
    check("lw_m2r", {31'd0, mem_to_reg_mem}, 32'd1);
    check("lw_rd", {27'd0, rd_mem}, 32'd7);
    check("lw_be", {28'd0, be_s}, 32'hF);
    check("lw_we", {31'd0, we_s}, 32'd0);
    check("lw_addr", ad_s, 32'h100);
    check("fpu_pass", fpu_result_mem, 32'h3F80_0000);
    tick(); go_idle();

    // Sub-word loads, ack after one wait cycle
    mem_op(32'h103, 3'b000, 1'b0, 32'h0, 32'h80123456, 1, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("lb_stall", st_n, 32'd3);
    check("lb_rdata", mem_rdata_mem, 32'hFFFFFF80);
    tick(); go_idle();
    mem_op(32'h103, 3'b100, 1'b0, 32'h0, 32'h80123456, 1, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("lbu_rdata", mem_rdata_mem, 32'h00000080);
    tick(); go_idle();
    mem_op(32'h102, 3'b001, 1'b0, 32'h0, 32'h80123456, 0, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("lh_rdata", mem_rdata_mem, 32'hFFFF8012);
    tick(); go_idle();
    mem_op(32'h102, 3'b101, 1'b0, 32'h0, 32'h80123456, 0, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("lhu_rdata", mem_rdata_mem, 32'h00008012);
    tick(); go_idle();

    // Stores
    mem_op(32'h201, 3'b000, 1'b1, 32'h000000A5, 32'h0, 0, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("sb_be", {28'd0, be_s}, 32'h2);
    check("sb_wdata", wd_s, 32'hA5A5A5A5);
    check("sb_addr", ad_s, 32'h200);
    check("sb_we", {31'd0, we_s}, 32'd1);
    tick(); go_idle();
    mem_op(32'h202, 3'b001, 1'b1, 32'h00001234, 32'h0, 0, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("sh_be", {28'd0, be_s}, 32'hC);
    check("sh_wdata", wd_s, 32'h12341234);
    tick(); go_idle();

    // Misaligned LW
    mem_op(32'h102, 3'b010, 1'b0, 32'h0, 32'h0, 0, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("mis_exc", {31'd0, misalign_exc}, 32'd1);
    check("mis_stall", st_n, 32'd0);
    check("mis_rw", {31'd0, reg_write_mem}, 32'd0);
    tick(); go_idle();
    @(negedge clk);
    check("mis_noreq", rq_n + {31'd0, dmem_req}, 32'd0);
    check("mis_pulse", {31'd0, misalign_exc}, 32'd0);
    tick();

    // Timeout: ack withheld
    mem_op(32'h300, 3'b010, 1'b0, 32'h0, 32'h0, -1, st_n, rq_n, we_s, be_s, ad_s, wd_s);
    check("to_reqcyc", rq_n, 32'd4);
    check("to_stall", st_n, 32'd5);
    check("to_buserr", {31'd0, bus_err}, 32'd1);
    check("to_rw", {31'd0, reg_write_mem}, 32'd0);
    tick(); go_idle();
    @(negedge clk);
    check("to_pulse", {31'd0, bus_err}, 32'd0);
    tick(); tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    check("late_ack_req", {31'd0, dmem_req}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rdata", mem_rdata_mem, 32'h0);
    check("late_ack_stall", {31'd0, mem_stall}, 32'd0);
    tick();

    // Reset during REQ
    ex_valid = 1'b1; mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h400;
    reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    tick();
    check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    dmem_ack = 1'b0;
    ex_valid = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
    addr_in = 32'h1234; rd_in = 5'd3; reg_write_in = 1'b1; mem_to_reg_in = 1'b0;
    @(negedge clk);
    check("add_stall", {31'd0, mem_stall}, 32'd0);
    check("add_rw", {31'd0, reg_write_mem}, 32'd1);
    check("add_alu", alu_result_mem, 32'h1234);
    check("add_rd", {27'd0, rd_mem}, 32'd3);
    check("add_rdata", mem_rdata_mem, 32'h0);
    tick(); go_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
